// File: rtl/shift_issue_stage.sv
// shift_issue_stage: decodes shift instructions and presents them to the shifter through a 2-entry skid buffer
module shift_issue_stage #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_funct3,
    input  logic [6:0]       i_funct7,
    input  logic             i_use_imm,
    input  logic [31:0]      i_rs1,
    input  logic [31:0]      i_rs2,
    input  logic [11:0]      i_imm,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_shf_data,
    output logic [4:0]       o_shf_shamt,
    output logic [1:0]       o_shf_op,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_issue_cnt
);
    logic [6:0]  w_f7;
    logic        w_sll;
    logic        w_srl;
    logic        w_sra;
    logic        w_legal;
    logic [1:0]  w_op;
    logic [4:0]  w_shamt;
    logic [31:0] w_data;
    logic        w_accept;
    logic        w_fire;
    logic        w_unused;

    logic             r_out_v;
    logic [31:0]      r_out_data;
    logic [4:0]       r_out_shamt;
    logic [1:0]       r_out_op;
    logic             r_out_ill;
    logic             r_sk_v;
    logic [31:0]      r_sk_data;
    logic [4:0]       r_sk_shamt;
    logic [1:0]       r_sk_op;
    logic             r_sk_ill;
    logic             r_ready;
    logic [CNT_W-1:0] r_cnt;

    assign w_unused = ^i_rs2[31:5];
    assign w_f7     = i_use_imm ? i_imm[11:5] : i_funct7;
    assign w_sll    = (i_funct3 == 3'b001) && (w_f7 == 7'b0000000);
    assign w_srl    = (i_funct3 == 3'b101) && (w_f7 == 7'b0000000);
    assign w_sra    = (i_funct3 == 3'b101) && (w_f7 == 7'b0100000);
    assign w_legal  = w_sll || w_srl || w_sra;
    assign w_op     = w_sra ? 2'b10 : (w_srl ? 2'b01 : 2'b00);
    assign w_shamt  = w_legal ? (i_use_imm ? i_imm[4:0] : i_rs2[4:0]) : 5'd0;
    assign w_data   = w_legal ? i_rs1 : 32'd0;
    assign w_accept = i_valid && r_ready;
    assign w_fire   = r_out_v && i_ready;

    // Output register and skid register; skid drains into OUT whenever OUT frees up
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_v     <= 1'b0;
            r_out_data  <= '0;
            r_out_shamt <= '0;
            r_out_op    <= '0;
            r_out_ill   <= 1'b0;
            r_sk_v      <= 1'b0;
            r_sk_data   <= '0;
            r_sk_shamt  <= '0;
            r_sk_op     <= '0;
            r_sk_ill    <= 1'b0;
            r_ready     <= 1'b1;
        end else if (i_flush) begin
            r_out_v <= 1'b0;
            r_sk_v  <= 1'b0;
            r_ready <= 1'b1;
        end else if (!r_out_v || w_fire) begin
            if (r_sk_v) begin
                r_out_v     <= 1'b1;
                r_out_data  <= r_sk_data;
                r_out_shamt <= r_sk_shamt;
                r_out_op    <= r_sk_op;
                r_out_ill   <= r_sk_ill;
                r_sk_v      <= 1'b0;
                r_ready     <= 1'b1;
            end else if (w_accept) begin
                r_out_v     <= 1'b1;
                r_out_data  <= w_data;
                r_out_shamt <= w_shamt;
                r_out_op    <= w_op;
                r_out_ill   <= !w_legal;
            end else begin
                r_out_v <= 1'b0;
            end
        end else if (w_accept) begin
            r_sk_v     <= 1'b1;
            r_sk_data  <= w_data;
            r_sk_shamt <= w_shamt;
            r_sk_op    <= w_op;
            r_sk_ill   <= !w_legal;
            r_ready    <= 1'b0;
        end
    end

    // Count legal entries handed to the shifter, including fires in a flush cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (w_fire && !r_out_ill)
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_ready     = r_ready;
    assign o_valid     = r_out_v;
    assign o_shf_data  = r_out_data;
    assign o_shf_shamt = r_out_shamt;
    assign o_shf_op    = r_out_op;
    assign o_illegal   = r_out_ill;
    assign o_issue_cnt = r_cnt;
endmodule
